// File: rtl/run_controller_if.sv
// Run-handshake bundle: host start/result port, processor req/done, data-memory read port.
// Latency: none, wires only.
// Backpressure: res_valid/res_ready on the result stream; the rest are level or pulse signals.
interface run_controller_if #(
    parameter int CW = 16,
    parameter int AW = 8
);
    logic          start;
    logic          dut_reset;
    logic          req;
    logic          done;
    logic [AW-1:0] mem_rd_addr;
    logic [7:0]    mem_rd_data;
    logic          res_valid;
    logic          res_ready;
    logic [7:0]    res_data;
    logic [AW-1:0] res_idx;
    logic          busy;
    logic          run_done;
    logic          timed_out;
    logic [CW-1:0] cycle_count;

    // Controller side.
    modport master (
        input  start, done, mem_rd_data, res_ready,
        output dut_reset, req, mem_rd_addr, res_valid, res_data, res_idx,
               busy, run_done, timed_out, cycle_count
    );

    // Host / processor / memory side.
    modport slave (
        output start, done, mem_rd_data, res_ready,
        input  dut_reset, req, mem_rd_addr, res_valid, res_data, res_idx,
               busy, run_done, timed_out, cycle_count
    );
endinterface

// File: rtl/run_controller.sv
// Run controller: resets the processor, pulses req, waits for done or timeout, then streams results.
// Latency: RST_CYC reset cycles + 1 req cycle + WAIT cycles + one cycle per accepted beat + 1 FIN cycle.
// Backpressure: result beats hold res_data/res_idx stable while res_ready is low.
module run_controller #(
    parameter int RST_CYC  = 2,
    parameter int TIMEOUT  = 4096,
    parameter int CW       = 16,
    parameter int AW       = 8,
    parameter int RES_BASE = 0,
    parameter int RES_LEN  = 8
) (
    input  logic              clk,
    input  logic              reset,
    run_controller_if.master  bus
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RST  = 3'd1,
        S_REQ  = 3'd2,
        S_WAIT = 3'd3,
        S_READ = 3'd4,
        S_FIN  = 3'd5,
        S_TMO  = 3'd6
    } state_t;

    localparam int             RCW      = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
    localparam logic [RCW-1:0] RST_LAST = RCW'(RST_CYC - 1);
    localparam logic [CW-1:0]  TMO_LIM  = CW'(TIMEOUT);
    localparam logic [AW-1:0]  BASE     = AW'(RES_BASE);
    // With RES_LEN == 0 this value is never used: WAIT skips READ entirely.
    localparam logic [AW-1:0]  IDX_LAST = AW'(RES_LEN - 1);
    localparam bit             NO_RES   = (RES_LEN == 0);

    state_t          state_q, state_d;
    logic [RCW-1:0]  rst_cnt_q, rst_cnt_d;
    logic [CW-1:0]   cycle_count_q, cycle_count_d;
    logic [AW-1:0]   res_idx_q, res_idx_d;
    logic            timed_out_q, timed_out_d;
    logic [CW-1:0]   cc_inc;

    logic            dut_reset_c;
    logic            req_c;
    logic            res_valid_c;
    logic [7:0]      res_data_c;
    logic [AW-1:0]   mem_rd_addr_c;
    logic            run_done_c;

    // State and counter registers; reset aborts any run in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            rst_cnt_q     <= '0;
            cycle_count_q <= '0;
            res_idx_q     <= '0;
            timed_out_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            rst_cnt_q     <= rst_cnt_d;
            cycle_count_q <= cycle_count_d;
            res_idx_q     <= res_idx_d;
            timed_out_q   <= timed_out_d;
        end
    end

    // Next-state, counter updates and Moore outputs (mem read data passes straight through in READ).
    always_comb begin
        state_d       = state_q;
        rst_cnt_d     = rst_cnt_q;
        cycle_count_d = cycle_count_q;
        res_idx_d     = res_idx_q;
        timed_out_d   = timed_out_q;
        cc_inc        = cycle_count_q + 1'b1;
        dut_reset_c   = 1'b0;
        req_c         = 1'b0;
        res_valid_c   = 1'b0;
        res_data_c    = 8'h00;
        mem_rd_addr_c = '0;
        run_done_c    = 1'b0;

        case (state_q)
            S_IDLE: begin
                dut_reset_c = 1'b1;
                if (bus.start) begin
                    state_d       = S_RST;
                    timed_out_d   = 1'b0;
                    cycle_count_d = '0;
                    rst_cnt_d     = '0;
                    res_idx_d     = '0;
                end
            end
            S_RST: begin
                dut_reset_c = 1'b1;
                if (rst_cnt_q == RST_LAST) begin
                    state_d = S_REQ;
                end else begin
                    rst_cnt_d = rst_cnt_q + 1'b1;
                end
            end
            S_REQ: begin
                // done is deliberately not looked at here.
                req_c   = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // The cycle in which done is seen is counted.
                cycle_count_d = cc_inc;
                if (bus.done) begin
                    state_d = NO_RES ? S_FIN : S_READ;
                end else if (cc_inc == TMO_LIM) begin
                    state_d = S_TMO;
                end
            end
            S_READ: begin
                // Address wraps naturally at the top of memory.
                mem_rd_addr_c = BASE + res_idx_q;
                res_valid_c   = 1'b1;
                res_data_c    = bus.mem_rd_data;
                if (bus.res_ready) begin
                    if (res_idx_q == IDX_LAST) begin
                        state_d   = S_FIN;
                        res_idx_d = '0;
                    end else begin
                        res_idx_d = res_idx_q + 1'b1;
                    end
                end
            end
            S_FIN: begin
                run_done_c = 1'b1;
                state_d    = S_IDLE;
            end
            S_TMO: begin
                timed_out_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.dut_reset   = dut_reset_c;
    assign bus.req         = req_c;
    assign bus.mem_rd_addr = mem_rd_addr_c;
    assign bus.res_valid   = res_valid_c;
    assign bus.res_data    = res_data_c;
    assign bus.res_idx     = res_idx_q;
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.run_done    = run_done_c;
    assign bus.timed_out   = timed_out_q;
    assign bus.cycle_count = cycle_count_q;
endmodule

// File: tb/tb_run_controller.sv
// Directed bench for run_controller: three instances cover base-0 readback, wrapped readback and RES_LEN=0.
// Memory model returns addr ^ 8'hA5; done/ready/start are driven cycle by cycle from tasks.
// Inputs change 1 time unit after posedge and outputs are sampled at the same point.
module tb_run_controller;
    logic clk;
    logic rst;

    int n_tests;
    int n_fail;

    run_controller_if #(.CW(16), .AW(8)) ifa ();
    run_controller_if #(.CW(16), .AW(8)) ifb ();
    run_controller_if #(.CW(16), .AW(8)) ifc ();

    run_controller #(.RST_CYC(2), .TIMEOUT(16), .CW(16), .AW(8), .RES_BASE(0), .RES_LEN(8))
        u_dut_a (.clk(clk), .reset(rst), .bus(ifa.master));
    run_controller #(.RST_CYC(2), .TIMEOUT(16), .CW(16), .AW(8), .RES_BASE(254), .RES_LEN(4))
        u_dut_b (.clk(clk), .reset(rst), .bus(ifb.master));
    run_controller #(.RST_CYC(2), .TIMEOUT(16), .CW(16), .AW(8), .RES_BASE(0), .RES_LEN(0))
        u_dut_c (.clk(clk), .reset(rst), .bus(ifc.master));

    assign ifa.mem_rd_data = ifa.mem_rd_addr ^ 8'hA5;
    assign ifb.mem_rd_data = ifb.mem_rd_addr ^ 8'hA5;
    assign ifc.mem_rd_data = ifc.mem_rd_addr ^ 8'hA5;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observations gathered by run_a.
    int         o_rst, o_req, o_beats, o_valid, o_rdone, o_stall_err;
    bit         o_finished;
    logic       o_to_at_start;
    logic [7:0] o_data [16];
    logic [7:0] o_idx  [16];
    logic [7:0] o_addr [16];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one run on instance A and records what it sees; comparisons live in the test tasks.
    // done_after: WAIT cycle number that sees done (0 = never); ready_mode 0 = always, 1 = 1,0,0 pattern.
    task automatic run_a(input int done_after, input int ready_mode,
                         input bit done_early, input bit start_in_wait);
        int         k;
        int         rcyc;
        bit         seen_req;
        bit         pstall;
        logic [7:0] pd;
        logic [7:0] pidx;
        k = 0; rcyc = 0; seen_req = 0; pstall = 0; pd = 0; pidx = 0;
        o_rst = 0; o_req = 0; o_beats = 0; o_valid = 0; o_rdone = 0; o_stall_err = 0;
        o_finished = 0;
        for (int i = 0; i < 16; i++) begin
            o_data[i] = 8'h00; o_idx[i] = 8'h00; o_addr[i] = 8'h00;
        end
        ifa.done = done_early;
        ifa.res_ready = 1'b0;
        ifa.start = 1'b1;
        tick();
        ifa.start = 1'b0;
        o_to_at_start = ifa.timed_out;
        for (int c = 0; c < 200; c++) begin
            if (pstall && ifa.res_valid && (ifa.res_data !== pd || ifa.res_idx !== pidx))
                o_stall_err++;
            if (!ifa.busy && !ifa.run_done) begin
                o_finished = 1;
                break;
            end
            if (ifa.busy && ifa.dut_reset) o_rst++;
            ifa.start = 1'b0;
            ifa.res_ready = 1'b0;
            if (ifa.req) begin
                o_req++;
                seen_req = 1;
                ifa.done = done_early;
            end else if (!seen_req) begin
                ifa.done = done_early;
            end else if (!ifa.res_valid && !ifa.run_done) begin
                k++;
                ifa.done  = (done_after != 0 && k == done_after);
                ifa.start = start_in_wait && (k == 2);
            end else begin
                ifa.done = 1'b0;
            end
            if (ifa.res_valid) begin
                o_valid++;
                ifa.res_ready = (ready_mode == 0) ? 1'b1 : (rcyc % 3 == 0);
                rcyc++;
                if (ifa.res_ready && o_beats < 16) begin
                    o_data[o_beats] = ifa.res_data;
                    o_idx[o_beats]  = ifa.res_idx;
                    o_addr[o_beats] = ifa.mem_rd_addr;
                    o_beats++;
                end
                pstall = !ifa.res_ready;
                pd     = ifa.res_data;
                pidx   = ifa.res_idx;
            end else begin
                pstall = 0;
            end
            if (ifa.run_done) o_rdone++;
            tick();
        end
        ifa.done = 1'b0;
        ifa.res_ready = 1'b0;
        ifa.start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_tests++; if (ifa.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", ifa.busy); end
        n_tests++; if (ifa.dut_reset !== 1'b1) begin n_fail++; $display("FAIL rst_dut_reset: got %b expected 1", ifa.dut_reset); end
        n_tests++; if ({ifa.req, ifa.res_valid, ifa.run_done, ifa.timed_out} !== 4'b0000) begin
            n_fail++; $display("FAIL rst_flags: got req/valid/done/tmo=%b expected 0000",
                               {ifa.req, ifa.res_valid, ifa.run_done, ifa.timed_out}); end
        n_tests++; if (ifa.cycle_count !== 16'd0 || ifa.mem_rd_addr !== 8'd0 || ifa.res_idx !== 8'd0) begin
            n_fail++; $display("FAIL rst_counts: got cc=%0d addr=%0d idx=%0d expected 0 0 0",
                               ifa.cycle_count, ifa.mem_rd_addr, ifa.res_idx); end
        rst = 1'b0;
        tick();
        n_tests++; if (ifa.busy !== 1'b0 || ifb.busy !== 1'b0 || ifc.busy !== 1'b0) begin
            n_fail++; $display("FAIL rst_idle_hold: got busy a/b/c=%b%b%b expected 000", ifa.busy, ifb.busy, ifc.busy); end
    endtask

    task automatic test_basic_run();
        run_a(10, 0, 0, 0);
        n_tests++; if (!o_finished) begin n_fail++; $display("FAIL t1_finished: got 0 expected 1"); end
        n_tests++; if (o_rst !== 2) begin n_fail++; $display("FAIL t1_rst_cycles: got %0d expected 2", o_rst); end
        n_tests++; if (o_req !== 1) begin n_fail++; $display("FAIL t1_req_cycles: got %0d expected 1", o_req); end
        n_tests++; if (ifa.cycle_count !== 16'd10) begin n_fail++; $display("FAIL t1_cycle_count: got %0d expected 10", ifa.cycle_count); end
        n_tests++; if (o_beats !== 8 || o_valid !== 8) begin n_fail++; $display("FAIL t1_beats: got beats=%0d valid=%0d expected 8 8", o_beats, o_valid); end
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if (o_addr[i] !== 8'(i) || o_data[i] !== (8'(i) ^ 8'hA5) || o_idx[i] !== 8'(i)) begin
                n_fail++; $display("FAIL t1_beat%0d: got addr=%0d data=%h idx=%0d expected %0d %h %0d",
                                   i, o_addr[i], o_data[i], o_idx[i], i, 8'(i) ^ 8'hA5, i);
            end
        end
        n_tests++; if (o_rdone !== 1) begin n_fail++; $display("FAIL t1_run_done: got %0d pulses expected 1", o_rdone); end
        n_tests++; if (ifa.dut_reset !== 1'b1 || ifa.timed_out !== 1'b0) begin
            n_fail++; $display("FAIL t1_after: got dut_reset=%b timed_out=%b expected 1 0", ifa.dut_reset, ifa.timed_out); end
    endtask

    task automatic test_backpressure();
        run_a(4, 1, 0, 0);
        n_tests++; if (o_beats !== 8) begin n_fail++; $display("FAIL t2_beats: got %0d expected 8", o_beats); end
        n_tests++; if (o_valid !== 22) begin n_fail++; $display("FAIL t2_valid_cycles: got %0d expected 22", o_valid); end
        n_tests++; if (o_stall_err !== 0) begin n_fail++; $display("FAIL t2_stable: got %0d changes while stalled expected 0", o_stall_err); end
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if (o_idx[i] !== 8'(i) || o_data[i] !== (8'(i) ^ 8'hA5)) begin
                n_fail++; $display("FAIL t2_beat%0d: got idx=%0d data=%h expected %0d %h",
                                   i, o_idx[i], o_data[i], i, 8'(i) ^ 8'hA5);
            end
        end
        n_tests++; if (o_rdone !== 1 || ifa.cycle_count !== 16'd4) begin
            n_fail++; $display("FAIL t2_done: got pulses=%0d cc=%0d expected 1 4", o_rdone, ifa.cycle_count); end
    endtask

    task automatic test_timeout();
        run_a(0, 0, 0, 0);
        n_tests++; if (!o_finished) begin n_fail++; $display("FAIL t3_finished: got 0 expected 1"); end
        n_tests++; if (ifa.timed_out !== 1'b1) begin n_fail++; $display("FAIL t3_timed_out: got %b expected 1", ifa.timed_out); end
        n_tests++; if (ifa.cycle_count !== 16'd16) begin n_fail++; $display("FAIL t3_cycle_count: got %0d expected 16", ifa.cycle_count); end
        n_tests++; if (o_valid !== 0 || o_rdone !== 0) begin
            n_fail++; $display("FAIL t3_no_output: got valid=%0d run_done=%0d expected 0 0", o_valid, o_rdone); end
        run_a(3, 0, 0, 0);
        n_tests++; if (o_to_at_start !== 1'b0) begin n_fail++; $display("FAIL t3_clear_on_start: got %b expected 0", o_to_at_start); end
        n_tests++; if (ifa.timed_out !== 1'b0 || ifa.cycle_count !== 16'd3 || o_rdone !== 1) begin
            n_fail++; $display("FAIL t3_rerun: got tmo=%b cc=%0d pulses=%0d expected 0 3 1",
                               ifa.timed_out, ifa.cycle_count, o_rdone); end
    endtask

    task automatic test_addr_wrap();
        int         nb;
        int         nd;
        logic [7:0] addrs [8];
        logic [7:0] datas [8];
        logic [7:0] exp_a [4];
        nb = 0; nd = 0;
        for (int i = 0; i < 8; i++) begin addrs[i] = 0; datas[i] = 0; end
        exp_a[0] = 8'd254; exp_a[1] = 8'd255; exp_a[2] = 8'd0; exp_a[3] = 8'd1;
        ifb.done = 1'b1;
        ifb.res_ready = 1'b1;
        ifb.start = 1'b1;
        tick();
        ifb.start = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (!ifb.busy && !ifb.run_done) break;
            if (ifb.res_valid && nb < 8) begin
                addrs[nb] = ifb.mem_rd_addr;
                datas[nb] = ifb.res_data;
                nb++;
            end
            if (ifb.run_done) nd++;
            tick();
        end
        ifb.done = 1'b0;
        ifb.res_ready = 1'b0;
        n_tests++; if (nb !== 4 || nd !== 1) begin n_fail++; $display("FAIL t4_beats: got beats=%0d pulses=%0d expected 4 1", nb, nd); end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (addrs[i] !== exp_a[i] || datas[i] !== (exp_a[i] ^ 8'hA5)) begin
                n_fail++; $display("FAIL t4_beat%0d: got addr=%0d data=%h expected %0d %h",
                                   i, addrs[i], datas[i], exp_a[i], exp_a[i] ^ 8'hA5);
            end
        end
    endtask

    task automatic test_zero_len();
        int nv;
        int nd;
        nv = 0; nd = 0;
        ifc.done = 1'b1;
        ifc.res_ready = 1'b1;
        ifc.start = 1'b1;
        tick();
        ifc.start = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (!ifc.busy && !ifc.run_done) break;
            if (ifc.res_valid) nv++;
            if (ifc.run_done) nd++;
            tick();
        end
        ifc.done = 1'b0;
        n_tests++; if (nv !== 0 || nd !== 1 || ifc.cycle_count !== 16'd1) begin
            n_fail++; $display("FAIL t_zero_len: got valid=%0d pulses=%0d cc=%0d expected 0 1 1", nv, nd, ifc.cycle_count); end
    endtask

    task automatic test_reset_mid_read();
        bit found;
        int nd;
        found = 0; nd = 0;
        ifa.done = 1'b1;
        ifa.res_ready = 1'b1;
        ifa.start = 1'b1;
        tick();
        ifa.start = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (ifa.res_valid && ifa.res_idx == 8'd3) begin
                found = 1;
                break;
            end
            tick();
        end
        n_tests++; if (!found) begin n_fail++; $display("FAIL t5_reach_beat3: got 0 expected 1"); end
        n_tests++; if (ifa.cycle_count !== 16'd1) begin n_fail++; $display("FAIL t5_first_wait_done: got %0d expected 1", ifa.cycle_count); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_tests++; if (ifa.busy !== 1'b0 || ifa.dut_reset !== 1'b1 || ifa.res_valid !== 1'b0) begin
            n_fail++; $display("FAIL t5_abort_state: got busy=%b dut_reset=%b valid=%b expected 0 1 0",
                               ifa.busy, ifa.dut_reset, ifa.res_valid); end
        n_tests++; if (ifa.cycle_count !== 16'd0) begin n_fail++; $display("FAIL t5_cc_cleared: got %0d expected 0", ifa.cycle_count); end
        for (int c = 0; c < 4; c++) begin
            if (ifa.run_done) nd++;
            tick();
        end
        ifa.done = 1'b0;
        ifa.res_ready = 1'b0;
        n_tests++; if (nd !== 0 || ifa.busy !== 1'b0) begin
            n_fail++; $display("FAIL t5_no_run_done: got pulses=%0d busy=%b expected 0 0", nd, ifa.busy); end
    endtask

    task automatic test_ignored_inputs();
        ifa.done = 1'b1;
        tick();
        tick();
        tick();
        n_tests++; if (ifa.busy !== 1'b0 || ifa.cycle_count !== 16'd0) begin
            n_fail++; $display("FAIL t6_done_in_idle: got busy=%b cc=%0d expected 0 0", ifa.busy, ifa.cycle_count); end
        run_a(5, 0, 1, 1);
        n_tests++; if (ifa.cycle_count !== 16'd5) begin n_fail++; $display("FAIL t6_cycle_count: got %0d expected 5", ifa.cycle_count); end
        n_tests++; if (o_beats !== 8 || o_rdone !== 1 || o_req !== 1) begin
            n_fail++; $display("FAIL t6_run: got beats=%0d pulses=%0d req=%0d expected 8 1 1", o_beats, o_rdone, o_req); end
        tick();
        tick();
        n_tests++; if (ifa.busy !== 1'b0) begin n_fail++; $display("FAIL t6_start_in_wait: got busy=%b expected 0", ifa.busy); end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        ifa.start = 1'b0; ifa.done = 1'b0; ifa.res_ready = 1'b0;
        ifb.start = 1'b0; ifb.done = 1'b0; ifb.res_ready = 1'b0;
        ifc.start = 1'b0; ifc.done = 1'b0; ifc.res_ready = 1'b0;
        test_reset();
        test_basic_run();
        test_backpressure();
        test_timeout();
        test_addr_wrap();
        test_zero_len();
        test_reset_mid_read();
        test_ignored_inputs();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
